// File: rtl/ahb_console_cnt_slave.sv
// AHB-Lite console / cycle-counter slave: DATA reads return a saturating cycle counter,
// DATA writes push a character into a TX FIFO drained over a valid/ready byte stream.
module ahb_console_cnt_slave #(
  parameter int FIFO_DEPTH = 8,
  parameter bit CNT_EN_RST = 1'b1
) (
  input  logic        sysclk,
  input  logic        sysrst_b,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        char_vld,
  output logic [7:0]  char_data,
  input  logic        char_rdy,
  output logic        fifo_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic {IDLE, WR_DATA} state_t;

  state_t      state, state_nxt;
  logic        accept, acc_wr_data, dp_ctrl_wr, push, pop, full;
  logic        cnt_en;
  logic [31:0] cnt, rd_mux;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        unused_ok;

  assign unused_ok   = ^{hsize, haddr[31:4], haddr[1:0], hwdata[31:8]};
  assign hresp       = 2'b00;
  assign accept      = hsel & htrans[1] & hready;
  assign acc_wr_data = accept & hwrite & (haddr[3:2] == 2'd0);

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign char_vld   = !fifo_empty;
  assign char_data  = mem[rd_ptr[AW-1:0]];
  assign pop        = char_vld & char_rdy;

  always_ff @(posedge sysclk) begin
    if (!sysrst_b) state <= IDLE;
    else           state <= state_nxt;
  end

  // A stalled DATA write completes as soon as a slot frees, including one freed by a same-cycle pop.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    hreadyout = 1'b1;
    case (state)
      IDLE: if (acc_wr_data) state_nxt = WR_DATA;
      WR_DATA: begin
        if (!full || pop) begin
          push      = 1'b1;
          state_nxt = acc_wr_data ? WR_DATA : IDLE;
        end else begin
          hreadyout = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!sysrst_b) begin
      dp_ctrl_wr <= 1'b0;
      cnt_en     <= CNT_EN_RST;
    end else begin
      if (hreadyout) dp_ctrl_wr <= accept & hwrite & (haddr[3:2] == 2'd2);
      if (dp_ctrl_wr) cnt_en <= hwdata[0];
    end
  end

  // Clear wins over increment; the counter holds at all-ones.
  always_ff @(posedge sysclk) begin
    if (!sysrst_b)                    cnt <= '0;
    else if (dp_ctrl_wr && hwdata[1]) cnt <= '0;
    else if (cnt_en && cnt != '1)     cnt <= cnt + 32'd1;
  end

  always_comb begin
    rd_mux = '0;
    case (haddr[3:2])
      2'd0:    rd_mux = cnt;
      2'd1:    rd_mux = {16'b0, 8'(count), 6'b0, full, fifo_empty};
      2'd2:    rd_mux = {31'b0, cnt_en};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!sysrst_b)             hrdata <= '0;
    else if (accept && !hwrite) hrdata <= rd_mux;
  end

  always_ff @(posedge sysclk) begin
    if (!sysrst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= hwdata[7:0];
  end

endmodule

// File: tb/tb_ahb_console_cnt_slave.sv
// Directed bench for ahb_console_cnt_slave: counter reads, FIFO ordering, full stall, saturation, clear, reset abort.
module tb_ahb_console_cnt_slave;

  logic        sysclk = 1'b0;
  logic        sysrst_b, hsel, hwrite, hreadyout, char_vld, char_rdy, fifo_empty;
  logic [31:0] haddr, hwdata, hrdata, d;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize;
  logic [7:0]  char_data;
  int          n_cmp = 0, n_err = 0, st;
  logic [7:0]  rxq[$];
  logic [7:0]  msg[9];

  always #5 sysclk = ~sysclk;

  ahb_console_cnt_slave #(.FIFO_DEPTH(8), .CNT_EN_RST(1'b1)) dut (
    .sysclk(sysclk), .sysrst_b(sysrst_b), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout), .hreadyout(hreadyout),
    .hrdata(hrdata), .hresp(hresp), .char_vld(char_vld), .char_data(char_data),
    .char_rdy(char_rdy), .fifo_empty(fifo_empty)
  );

  always @(negedge sysclk)
    if (sysrst_b && char_vld && char_rdy) rxq.push_back(char_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
  endtask

  task automatic ahb_rd(input logic [31:0] a, output logic [31:0] rd);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
    @(posedge sysclk); #1;
    bus_idle();
    rd = hrdata;
  endtask

  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] wd, output int stalls);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    @(posedge sysclk); #1;
    bus_idle();
    hwdata = wd;
    stalls = 0;
    @(negedge sysclk);
    while (!hreadyout && stalls < 100) begin
      stalls++;
      @(negedge sysclk);
    end
    @(posedge sysclk); #1;
  endtask

  initial begin
    bus_idle(); hsize = 3'd2; hwdata = '0; char_rdy = 1'b0; sysrst_b = 1'b0;
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    repeat (2) @(posedge sysclk); #1;
    sysrst_b = 1'b1;

    // reset state and free-running counter
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_char_vld", 32'(char_vld), 32'd0);
    chk("rst_hresp", 32'(hresp), 32'd0);
    repeat (100) @(posedge sysclk); #1;
    ahb_rd(32'h0, d); chk("cnt_100", d, 32'd100);
    ahb_rd(32'h0, d); chk("cnt_101", d, 32'd101);
    ahb_rd(32'h8, d); chk("ctrl_default", d, 32'd1);
    ahb_rd(32'h4, d); chk("status_empty", d, 32'h1);

    // "Hi" with consumer ready
    char_rdy = 1'b1; rxq.delete();
    ahb_wr(32'h0, 32'h48, st); chk("hi_stall0", 32'(st), 32'd0);
    ahb_wr(32'h0, 32'h69, st); chk("hi_stall1", 32'(st), 32'd0);
    repeat (3) @(posedge sysclk); #1;
    chk("hi_count", 32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      chk("hi_0", 32'(rxq[0]), 32'h48);
      chk("hi_1", 32'(rxq[1]), 32'h69);
    end

    // fill to full, ninth write stalls until a single pop
    char_rdy = 1'b0; rxq.delete();
    for (int i = 0; i < 8; i++) begin
      ahb_wr(32'h0, 32'(msg[i]), st); chk("fill_stall", 32'(st), 32'd0);
    end
    ahb_rd(32'h4, d); chk("status_full", d, 32'h0000_0802);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0;
    @(posedge sysclk); #1;
    bus_idle(); hwdata = 32'(msg[8]);
    @(negedge sysclk); chk("stall_a", 32'(hreadyout), 32'd0);
    @(posedge sysclk); #1;
    @(negedge sysclk); chk("stall_b", 32'(hreadyout), 32'd0);
    @(posedge sysclk); #1;
    char_rdy = 1'b1;
    @(negedge sysclk); chk("stall_release", 32'(hreadyout), 32'd1);
    @(posedge sysclk); #1;
    char_rdy = 1'b0;
    ahb_rd(32'h4, d); chk("status_still_full", d, 32'h0000_0802);
    char_rdy = 1'b1;
    repeat (12) @(posedge sysclk); #1;
    char_rdy = 1'b0;
    chk("drain_count", 32'(rxq.size()), 32'd9);
    if (rxq.size() == 9)
      for (int i = 0; i < 9; i++) chk($sformatf("drain_%0d", i), 32'(rxq[i]), 32'(msg[i]));

    // saturation
    @(negedge sysclk);
    force dut.cnt = 32'hFFFF_FFFD;
    @(posedge sysclk); #1;
    release dut.cnt;
    repeat (10) @(posedge sysclk); #1;
    ahb_rd(32'h0, d); chk("sat_a", d, 32'hFFFF_FFFF);
    ahb_rd(32'h0, d); chk("sat_b", d, 32'hFFFF_FFFF);

    // clear + enable, then disable
    ahb_wr(32'h8, 32'h3, st);
    ahb_rd(32'h0, d); chk("clr_0", d, 32'd0);
    ahb_rd(32'h0, d); chk("clr_1", d, 32'd1);
    ahb_wr(32'h8, 32'h0, st);
    repeat (5) @(posedge sysclk); #1;
    ahb_rd(32'h0, d); chk("frozen_a", d, 32'd4);
    ahb_rd(32'h0, d); chk("frozen_b", d, 32'd4);
    ahb_rd(32'h8, d); chk("ctrl_off", d, 32'd0);
    ahb_wr(32'hC, 32'hFF, st); chk("unmapped_wr_stall", 32'(st), 32'd0);
    ahb_rd(32'hC, d); chk("unmapped_rd", d, 32'd0);

    // reset during stalled write
    rxq.delete();
    for (int i = 0; i < 8; i++) ahb_wr(32'h0, 32'(msg[i]), st);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0;
    @(posedge sysclk); #1;
    bus_idle(); hwdata = 32'h5A;
    @(negedge sysclk); chk("pre_rst_stall", 32'(hreadyout), 32'd0);
    @(posedge sysclk); #1;
    sysrst_b = 1'b0;
    @(posedge sysclk); #1;
    sysrst_b = 1'b1;
    chk("mid_rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    chk("mid_rst_char_vld", 32'(char_vld), 32'd0);
    chk("mid_rst_hrdata", hrdata, 32'd0);
    repeat (3) @(posedge sysclk); #1;
    chk("post_rst_char_vld", 32'(char_vld), 32'd0);
    ahb_rd(32'h4, d); chk("post_rst_status", d, 32'h1);
    ahb_rd(32'h8, d); chk("post_rst_ctrl", d, 32'd1);
    chk("post_rst_rx", 32'(rxq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
